// File: rtl/crc7_pkg.sv
// Shared definitions for the CRC-7 (x^7 + x^3 + 1) encoder/checker family:
// field widths, the generator's low-order terms, the checker FSM state type
// and a helper that yields the syndrome of a single-bit error.
package crc7_pkg;

    localparam int CRC7_DATA_W = 16;
    localparam int CRC7_W      = 7;
    localparam int CRC7_CW_W   = CRC7_DATA_W + CRC7_W;

    // Generator terms below x^7; the x^7 term is implied by the register width.
    localparam logic [CRC7_W-1:0] CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FIX,
        ST_DONE
    } crc7_state_e;

    // Syndrome left by an error in codeword bit p alone: x^p mod g.
    // The loop has a constant bound so it unrolls into constants when p is
    // itself a loop constant at the call site.
    function automatic logic [CRC7_W-1:0] crc7_bit_syndrome(input int p);
        logic [CRC7_W-1:0] s;
        s = CRC7_W'(1);
        for (int i = 0; i < CRC7_CW_W; i++) begin
            if (i < p) begin
                s = {s[CRC7_W-2:0], 1'b0} ^ (s[CRC7_W-1] ? CRC7_POLY : '0);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/crc7_serial_rem.sv
// Bit-serial CRC-7 remainder register with synchronous clear and enable.
// It is a plain polynomial divider: each bit enters at the low end and the
// x^7 overflow folds back as POLY, so after a whole codeword the register
// holds codeword mod g. A clean codeword leaves zero and a lone error in bit
// p leaves x^p mod g.
module crc7_serial_rem #(
    parameter int           W    = 7,
    parameter logic [W-1:0] POLY = 7'h09
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         bit_i,
    output logic [W-1:0] rem_o
);

    logic [W-1:0] rem_q;
    logic [W-1:0] rem_d;

    // Next remainder: clear wins over a shift step.
    always_comb begin
        rem_d = rem_q;
        if (clr_i) begin
            rem_d = '0;
        end else if (en_i) begin
            rem_d = {rem_q[W-2:0], bit_i} ^ (rem_q[W-1] ? POLY : '0);
        end
    end

    // Remainder state.
    // NOTE: state is only ever assigned with <= here so every flop samples
    // values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem_o = rem_q;

endmodule

// File: rtl/crc7_check.sv
// Receive-side CRC-7 checker. Takes {data, crc} over valid/ready, divides the
// codeword MSB first through crc7_serial_rem, then presents the data, the
// pass/fail verdict and the syndrome, and keeps a saturating count of failed
// codewords.
// Build option CRC7_CORRECT_EN: adds a FIX state that repairs any single-bit
// error and an extra output port 'corrected'.
module crc7_check
    import crc7_pkg::*;
#(
    parameter int                DATA_W = CRC7_DATA_W,
    parameter int                CRC_W  = CRC7_W,
    parameter logic [CRC_W-1:0]  POLY   = CRC7_POLY,
    parameter int                CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W+CRC_W-1:0]   codeword_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         data_out,
    output logic                      crc_ok,
    output logic [CRC_W-1:0]          syndrome,
    output logic [CNT_W-1:0]          err_count
`ifdef CRC7_CORRECT_EN
    ,
    output logic                      corrected
`endif
);

    localparam int CW_W      = DATA_W + CRC_W;
    localparam int BIT_CNT_W = $clog2(CW_W);

    crc7_state_e            state_q;
    logic [CW_W-1:0]        cw_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [DATA_W-1:0]      data_out_q;
    logic [CNT_W-1:0]       err_count_q;
    logic [CNT_W-1:0]       err_count_d;
    logic [CRC_W-1:0]       rem;
    logic                   accept;
    logic                   rem_ok;

    assign accept = in_valid && in_ready_q;
    assign rem_ok = (rem == '0);

    // The remainder register doubles as the syndrome register: it is cleared
    // on accept and then holds the final remainder until the next accept.
    crc7_serial_rem #(
        .W    (CRC_W),
        .POLY (POLY)
    ) u_rem (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (accept),
        .en_i  (state_q == ST_SHIFT),
        .bit_i (cw_q[bit_cnt_q]),
        .rem_o (rem)
    );

`ifdef CRC7_CORRECT_EN
    // Single-bit error locator. The syndromes x^p mod g are distinct for
    // p < 127, so at most one position can match; zero never matches.
    logic [CW_W-1:0]   hit;
    logic [DATA_W-1:0] data_flip;
    logic              fix_hit;
    logic              corrected_q;

    // Compare the final remainder against every single-bit syndrome.
    always_comb begin
        hit = '0;
        for (int p = 0; p < CW_W; p++) begin
            hit[p] = (rem == crc7_bit_syndrome(p));
        end
    end

    // Hits below CRC_W land in the CRC field and leave the data untouched.
    assign data_flip = hit[CW_W-1:CRC_W];
    assign fix_hit   = |hit;
    assign corrected = corrected_q;
`endif

    // Saturating failure count, advanced only on a failing result handshake.
    always_comb begin
        err_count_d = err_count_q;
        if (!rem_ok && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // Control FSM with registered handshake and data outputs.
    // NOTE: the async reset clears only control and output flops; cw_q is
    // also cleared so the serial bit input is never X after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cw_q        <= '0;
            bit_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            err_count_q <= '0;
`ifdef CRC7_CORRECT_EN
            corrected_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cw_q       <= codeword_in;
                        data_out_q <= codeword_in[CW_W-1 -: DATA_W];
                        bit_cnt_q  <= BIT_CNT_W'(CW_W - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SHIFT;
`ifdef CRC7_CORRECT_EN
                        corrected_q <= 1'b0;
`endif
                    end
                end

                ST_SHIFT: begin
                    if (bit_cnt_q == '0) begin
`ifdef CRC7_CORRECT_EN
                        state_q     <= ST_FIX;
`else
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
`endif
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end

`ifdef CRC7_CORRECT_EN
                ST_FIX: begin
                    data_out_q  <= data_out_q ^ data_flip;
                    corrected_q <= fix_hit;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
`endif

                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        err_count_q <= err_count_d;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign syndrome  = rem;
    // Verdict is only meaningful with a result; it reads 0 otherwise.
    assign crc_ok    = out_valid_q && rem_ok;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_crc7_check.sv
// Directed bench for crc7_check. Expected values are hand-derived from
// g = x^7 + x^3 + 1: a codeword's syndrome is codeword mod g, so a single
// error in bit p leaves x^p mod g (x^0 -> 01, x^22 -> 53).
// Compile with +define+CRC7_CORRECT_EN to check the correcting build.
module tb_crc7_check;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] codeword_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
    logic        crc_ok;
    logic [6:0]  syndrome;
    logic [7:0]  err_count;
`ifdef CRC7_CORRECT_EN
    logic        corrected;
    localparam int LAT = 25;
`else
    localparam int LAT = 24;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    crc7_check dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .codeword_in (codeword_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .crc_ok      (crc_ok),
        .syndrome    (syndrome),
        .err_count   (err_count)
`ifdef CRC7_CORRECT_EN
        ,
        .corrected   (corrected)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Offers cw, waits for the accept edge, then counts
    // negedges until out_valid is seen (first negedge after accept = 1).
    task automatic run_cw(input logic [22:0] cw, output int cycles);
        int guard;
        guard       = 0;
        codeword_in = cw;
        in_valid    = 1'b1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cycles = 0;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (out_valid) break;
        end
        if (!out_valid) check("result_timeout", out_valid, 1);
    endtask

    // Called at a negedge with out_ready=1 and a result showing.
    task automatic finish_hs();
        @(negedge clk);
        check("hs_out_valid_low", out_valid, 0);
        check("hs_in_ready_high", in_ready, 1);
    endtask

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        codeword_in = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_crc_ok", crc_ok, 0);
        check("rst_syndrome", syndrome, 0);
        check("rst_err_count", err_count, 0);
`ifdef CRC7_CORRECT_EN
        check("rst_corrected", corrected, 0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Clean codeword, out_ready high before the result appears
        out_ready = 1'b1;
        run_cw(23'h000089, lat);
        check("t1_latency", lat, LAT);
        check("t1_data", data_out, 16'h0001);
        check("t1_crc_ok", crc_ok, 1);
        check("t1_syndrome", syndrome, 0);
        check("t1_in_ready", in_ready, 0);
`ifdef CRC7_CORRECT_EN
        check("t1_corrected", corrected, 0);
`endif
        finish_hs();
        check("t1_err_count", err_count, 0);

        // Result held under back-pressure
        out_ready = 1'b0;
        run_cw(23'h400053, lat);
        check("t2_latency", lat, LAT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_data", data_out, 16'h8000);
            check("t2_hold_crc_ok", crc_ok, 1);
            check("t2_hold_syndrome", syndrome, 0);
            check("t2_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        finish_hs();
        check("t2_err_count", err_count, 0);

        // Bit 22 flipped: data field reads 8001
        run_cw(23'h400089, lat);
        check("t3_syndrome", syndrome, 7'h53);
        check("t3_crc_ok", crc_ok, 0);
        check("t3_err_before_hs", err_count, 0);
`ifdef CRC7_CORRECT_EN
        check("t3_data", data_out, 16'h0001);
        check("t3_corrected", corrected, 1);
`else
        check("t3_data", data_out, 16'h8001);
`endif
        finish_hs();
        check("t3_err_count", err_count, 1);

        // All-zero codeword
        run_cw(23'h000000, lat);
        check("t4_zero_crc_ok", crc_ok, 1);
        check("t4_zero_syndrome", syndrome, 0);
        check("t4_zero_data", data_out, 0);
        finish_hs();

        // Bit 0 flipped: CRC field error, data unchanged in both builds
        run_cw(23'h000088, lat);
        check("t4_b0_syndrome", syndrome, 7'h01);
        check("t4_b0_crc_ok", crc_ok, 0);
        check("t4_b0_data", data_out, 16'h0001);
`ifdef CRC7_CORRECT_EN
        check("t4_b0_corrected", corrected, 1);
`endif
        finish_hs();
        check("t4_err_count", err_count, 2);

        // Drive the counter to its ceiling, then one more failure
        for (int i = 0; i < 253; i++) begin
            run_cw(23'h000088, lat);
            finish_hs();
        end
        check("sat_reached", err_count, 8'hFF);
        run_cw(23'h000088, lat);
        check("sat_crc_ok", crc_ok, 0);
        finish_hs();
        check("sat_held", err_count, 8'hFF);

        // Reset in the middle of SHIFT abandons the codeword
        check("t5_idle_ready", in_ready, 1);
        codeword_in = 23'h000089;
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_busy_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_in_ready", in_ready, 1);
        check("t5_rst_err_count", err_count, 0);
        check("t5_rst_syndrome", syndrome, 0);
        repeat (2) @(negedge clk);
        check("t5_rst_no_result", out_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        run_cw(23'h000089, lat);
        check("t5_latency", lat, LAT);
        check("t5_crc_ok", crc_ok, 1);
        check("t5_syndrome", syndrome, 0);
        check("t5_data", data_out, 16'h0001);
        finish_hs();
        check("t5_err_count", err_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
